// File: rtl/redirect_ctrl_pkg.sv
// Shared types and constants for the control-flow redirect sequencer.
package redirect_ctrl_pkg;

  // Redirect sequencer states, binary encoded.
  typedef enum logic [1:0] {
    RC_IDLE     = 2'd0,
    RC_REDIRECT = 2'd1,
    RC_DRAIN    = 2'd2
  } rc_state_e;

  // Instructions are word aligned: the low two PC bits are always zero.
  localparam logic [31:0] INSTR_ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/fetch_inflight_cnt.sv
// Up/down counter of outstanding memory requests, holding on protocol violations.
module fetch_inflight_cnt #(
  parameter  int unsigned MAX_OUTST = 2,
  localparam int unsigned CW        = $clog2(MAX_OUTST + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_count_nxt
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          viol_inc;
  logic          viol_dec;

  // Next count; a request at the ceiling or a response at zero leaves it unchanged.
  always_comb begin
    viol_inc = i_inc && (count_q == CW'(MAX_OUTST));
    viol_dec = i_dec && (count_q == '0);
    count_d  = count_q;
    if (!(viol_inc || viol_dec)) begin
      count_d = count_q + CW'(i_inc) - CW'(i_dec);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) count_q <= '0;
    else          count_q <= count_d;
  end

`ifndef SYNTHESIS
  // Protocol checks on the request/response strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!viol_inc) else $error("fetch_inflight_cnt: request issued at max outstanding");
      assert (!viol_dec) else $error("fetch_inflight_cnt: response with nothing outstanding");
    end
  end
`endif

  assign o_count     = count_q;
  assign o_count_nxt = count_d;

endmodule

// File: rtl/redirect_ctrl.sv
// Redirect sequencer: flushes IF/ID, hands the branch target to fetch, stalls EX
// until accepted, and discards wrong-path fetch responses still in flight.
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ex_valid,
  input  logic              i_branch_en,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_fetch_req_fire,
  input  logic              i_fetch_rsp_fire,
  output logic              o_redir_valid,
  output logic [ADDR_W-1:0] o_redir_pc,
  input  logic              i_redir_ready,
  output logic              o_flush,
  output logic              o_stall,
  output logic              o_rsp_drop,
  output logic [31:0]       o_taken_cnt
);

  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  rc_state_e         state_q,       state_d;
  logic [CW-1:0]     drop_cnt_q,    drop_cnt_d;
  logic [ADDR_W-1:0] target_q,      target_d;
  logic [31:0]       taken_cnt_q,   taken_cnt_d;
  logic              redir_valid_q, redir_valid_d;
  logic              stall_q,       stall_d;

  logic [CW-1:0]     outst;
  logic [CW-1:0]     outst_nxt;
  logic              cap;
  logic              rsp_drop;

  // Outstanding fetch request tracker.
  fetch_inflight_cnt #(
    .MAX_OUTST (MAX_OUTST)
  ) u_inflight (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_inc       (i_fetch_req_fire),
    .i_dec       (i_fetch_rsp_fire),
    .o_count     (outst),
    .o_count_nxt (outst_nxt)
  );

  // Next-state, drop accounting and capture logic.
  always_comb begin
    state_d     = state_q;
    drop_cnt_d  = drop_cnt_q;
    target_d    = target_q;
    taken_cnt_d = taken_cnt_q;

    cap      = i_ex_valid && i_branch_en && (state_q != RC_REDIRECT);
    rsp_drop = i_fetch_rsp_fire && ((drop_cnt_q != '0) || cap);

    if (cap) begin
      // Everything in flight after this edge belongs to the old path.
      target_d    = i_target & ~ADDR_W'(INSTR_ALIGN_MASK);
      drop_cnt_d  = outst_nxt;
      taken_cnt_d = taken_cnt_q + 32'd1;
      state_d     = RC_REDIRECT;
    end else begin
      unique case (state_q)
        RC_REDIRECT: begin
          drop_cnt_d = drop_cnt_q + CW'(i_fetch_req_fire) - CW'(rsp_drop);
          if (i_redir_ready) state_d = (drop_cnt_d != '0) ? RC_DRAIN : RC_IDLE;
        end
        RC_DRAIN: begin
          drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
          if (drop_cnt_d == '0) state_d = RC_IDLE;
        end
        default: begin
          drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
          state_d    = RC_IDLE;
        end
      endcase
    end

    redir_valid_d = (state_d == RC_REDIRECT);
    stall_d       = (state_d == RC_REDIRECT);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= RC_IDLE;
      drop_cnt_q    <= '0;
      target_q      <= '0;
      taken_cnt_q   <= '0;
      redir_valid_q <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      drop_cnt_q    <= drop_cnt_d;
      target_q      <= target_d;
      taken_cnt_q   <= taken_cnt_d;
      redir_valid_q <= redir_valid_d;
      stall_q       <= stall_d;
    end
  end

  assign o_redir_valid = redir_valid_q;
  assign o_redir_pc    = target_q;
  assign o_stall       = stall_q;
  assign o_taken_cnt   = taken_cnt_q;
  assign o_flush       = cap;
  assign o_rsp_drop    = rsp_drop;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Bench for redirect_ctrl: directed vector table, reset corner cases, and a
// randomized run against a path-tagged in-flight queue model.
module tb_redirect_ctrl;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned MAX_OUTST = 3;

  logic              clk;
  logic              rst_n;
  logic              ex_valid;
  logic              branch_en;
  logic [ADDR_W-1:0] target;
  logic              req_fire;
  logic              rsp_fire;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              redir_ready;
  logic              flush;
  logic              stall;
  logic              rsp_drop;
  logic [31:0]       taken_cnt;

  int checks;
  int failures;

  redirect_ctrl #(
    .ADDR_W    (ADDR_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_ex_valid       (ex_valid),
    .i_branch_en      (branch_en),
    .i_target         (target),
    .i_fetch_req_fire (req_fire),
    .i_fetch_rsp_fire (rsp_fire),
    .o_redir_valid    (redir_valid),
    .o_redir_pc       (redir_pc),
    .i_redir_ready    (redir_ready),
    .o_flush          (flush),
    .o_stall          (stall),
    .o_rsp_drop       (rsp_drop),
    .o_taken_cnt      (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in_bits = {ex_valid, branch_en, req, rsp, ready}; exp_bits = {flush, drop, valid, stall}
  typedef struct {
    logic [4:0]  in_bits;
    logic [31:0] tgt;
    logic [3:0]  exp_bits;
    logic [31:0] exp_pc;
    logic [31:0] exp_taken;
  } vec_t;

  vec_t tbl[27];

  // Reference model: one entry per in-flight request, 1 = wrong path.
  bit          mq[$];
  bit          m_pend;
  logic [31:0] m_pc;
  logic [31:0] m_taken;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic br, input logic [31:0] tg,
                       input logic rq, input logic rs, input logic rdy);
    ex_valid    = ev;
    branch_en   = br;
    target      = tg;
    req_fire    = rq;
    rsp_fire    = rs;
    redir_ready = rdy;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " valid"}, 32'(redir_valid), 32'd0);
    chk({tag, " pc"},    redir_pc,         32'd0);
    chk({tag, " stall"}, 32'(stall),       32'd0);
    chk({tag, " flush"}, 32'(flush),       32'd0);
    chk({tag, " drop"},  32'(rsp_drop),    32'd0);
    chk({tag, " taken"}, taken_cnt,        32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend  = 1'b0;
    m_pc    = '0;
    m_taken = '0;
  endtask

  // Apply the rules for one rising edge using the inputs present this cycle.
  task automatic model_edge();
    bit cap;
    cap = ex_valid && branch_en && !m_pend;
    if (rsp_fire && mq.size() > 0) void'(mq.pop_front());
    if (req_fire) mq.push_back(m_pend);
    if (cap) begin
      foreach (mq[i]) mq[i] = 1'b1;
      m_pend  = 1'b1;
      m_pc    = target & 32'hFFFF_FFFC;
      m_taken = m_taken + 32'd1;
    end else if (m_pend && redir_ready) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic model_check(input int cyc);
    bit cap;
    bit exp_drop;
    cap      = ex_valid && branch_en && !m_pend;
    exp_drop = rsp_fire && (cap || (mq.size() > 0 && mq[0]));
    chk($sformatf("rand%0d flush", cyc), 32'(flush),       32'(cap));
    chk($sformatf("rand%0d drop",  cyc), 32'(rsp_drop),    32'(exp_drop));
    chk($sformatf("rand%0d valid", cyc), 32'(redir_valid), 32'(m_pend));
    chk($sformatf("rand%0d stall", cyc), 32'(stall),       32'(m_pend));
    chk($sformatf("rand%0d pc",    cyc), redir_pc,         m_pc);
    chk($sformatf("rand%0d taken", cyc), taken_cnt,        m_taken);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    tbl[0]  = '{5'b11001, 32'h0000_1003, 4'b1000, 32'h0000_0000, 32'd0};
    tbl[1]  = '{5'b00001, 32'h0,         4'b0011, 32'h0000_1000, 32'd1};
    tbl[2]  = '{5'b00000, 32'h0,         4'b0000, 32'h0000_1000, 32'd1};
    tbl[3]  = '{5'b11000, 32'h0000_3004, 4'b1000, 32'h0000_1000, 32'd1};
    tbl[4]  = '{5'b11000, 32'h0000_7777, 4'b0011, 32'h0000_3004, 32'd2};
    tbl[5]  = '{5'b00000, 32'h0,         4'b0011, 32'h0000_3004, 32'd2};
    tbl[6]  = '{5'b11000, 32'h0000_8888, 4'b0011, 32'h0000_3004, 32'd2};
    tbl[7]  = '{5'b00001, 32'h0,         4'b0011, 32'h0000_3004, 32'd2};
    tbl[8]  = '{5'b00000, 32'h0,         4'b0000, 32'h0000_3004, 32'd2};
    tbl[9]  = '{5'b00100, 32'h0,         4'b0000, 32'h0000_3004, 32'd2};
    tbl[10] = '{5'b00100, 32'h0,         4'b0000, 32'h0000_3004, 32'd2};
    tbl[11] = '{5'b11000, 32'h0000_4000, 4'b1000, 32'h0000_3004, 32'd2};
    tbl[12] = '{5'b00101, 32'h0,         4'b0011, 32'h0000_4000, 32'd3};
    tbl[13] = '{5'b00010, 32'h0,         4'b0100, 32'h0000_4000, 32'd3};
    tbl[14] = '{5'b00010, 32'h0,         4'b0100, 32'h0000_4000, 32'd3};
    tbl[15] = '{5'b00110, 32'h0,         4'b0100, 32'h0000_4000, 32'd3};
    tbl[16] = '{5'b00010, 32'h0,         4'b0000, 32'h0000_4000, 32'd3};
    tbl[17] = '{5'b00000, 32'h0,         4'b0000, 32'h0000_4000, 32'd3};
    tbl[18] = '{5'b00100, 32'h0,         4'b0000, 32'h0000_4000, 32'd3};
    tbl[19] = '{5'b11111, 32'h0000_5000, 4'b1100, 32'h0000_4000, 32'd3};
    tbl[20] = '{5'b00001, 32'h0,         4'b0011, 32'h0000_5000, 32'd4};
    tbl[21] = '{5'b00100, 32'h0,         4'b0000, 32'h0000_5000, 32'd4};
    tbl[22] = '{5'b11001, 32'h0000_2000, 4'b1000, 32'h0000_5000, 32'd4};
    tbl[23] = '{5'b00001, 32'h0,         4'b0011, 32'h0000_2000, 32'd5};
    tbl[24] = '{5'b00010, 32'h0,         4'b0100, 32'h0000_2000, 32'd5};
    tbl[25] = '{5'b00010, 32'h0,         4'b0100, 32'h0000_2000, 32'd5};
    tbl[26] = '{5'b00000, 32'h0,         4'b0000, 32'h0000_2000, 32'd5};

    // Power-on reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    rst_n = 1'b1;

    // Directed vector table
    foreach (tbl[i]) begin
      drive(tbl[i].in_bits[4], tbl[i].in_bits[3], tbl[i].tgt,
            tbl[i].in_bits[2], tbl[i].in_bits[1], tbl[i].in_bits[0]);
      @(negedge clk);
      chk($sformatf("vec%0d flush", i), 32'(flush),       32'(tbl[i].exp_bits[3]));
      chk($sformatf("vec%0d drop",  i), 32'(rsp_drop),    32'(tbl[i].exp_bits[2]));
      chk($sformatf("vec%0d valid", i), 32'(redir_valid), 32'(tbl[i].exp_bits[1]));
      chk($sformatf("vec%0d stall", i), 32'(stall),       32'(tbl[i].exp_bits[0]));
      chk($sformatf("vec%0d pc",    i), redir_pc,         tbl[i].exp_pc);
      chk($sformatf("vec%0d taken", i), taken_cnt,        tbl[i].exp_taken);
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of a stalled redirect
    drive(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst pre valid", 32'(redir_valid), 32'd1);
    chk("midrst pre pc",    redir_pc,         32'h0000_0100);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("postrst");
    @(posedge clk);
    #1;

    // Randomized run against the model, with occasional resets
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 997 == 996) begin
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
      end
      drive(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom(),
            (mq.size() < MAX_OUTST) && ($urandom_range(0, 1) == 1),
            (mq.size() > 0) && ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) != 0));
      @(negedge clk);
      model_check(cyc);
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
